// File: rtl/multi_cycle_controller.sv
// Moore control FSM and ALU decoder for the multi-cycle RV32I datapath; one instruction in flight.
// Outputs are combinational from state and decode fields; write enables are suppressed while RESET is high.
module multi_cycle_controller (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] OP,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] ResultSrc,
  output logic [2:0] ALUControl,
  output logic       AdrSrc,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       Illegal
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMREAD  = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWRITE = 4'd5;
  localparam logic [3:0] EXECUTER = 4'd6;
  localparam logic [3:0] EXECUTEI = 4'd7;
  localparam logic [3:0] ALUWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] ILLEGAL  = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_SUB   = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0] state, next_state;
  logic [1:0] alu_op;
  logic       pc_update, branch, take;
  logic       mem_write_s, reg_write_s, ir_write_s;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        case (OP)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_R:         next_state = EXECUTER;
          OP_I:         next_state = EXECUTEI;
          OP_BR:        next_state = BRANCH;
          OP_JAL:       next_state = JAL;
          default:      next_state = ILLEGAL;
        endcase
      end
      MEMADR:   next_state = (OP == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  next_state = MEMWB;
      EXECUTER: next_state = ALUWB;
      EXECUTEI: next_state = ALUWB;
      JAL:      next_state = ALUWB;
      ILLEGAL:  next_state = ILLEGAL;
      default:  next_state = FETCH;
    endcase
  end

  always_comb begin
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ImmSrc      = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    alu_op      = ALUOP_ADD;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_write_s = 1'b0;
    reg_write_s = 1'b0;
    ir_write_s  = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = 1'b1;
        pc_update  = 1'b1;
      end
      DECODE: begin
        // Speculatively computes the branch target into ALUOut
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = 2'b10;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = (OP == OP_SW) ? 2'b01 : 2'b00;
      end
      MEMREAD: AdrSrc = 1'b1;
      MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = ALUOP_FUNCT;
      end
      ALUWB:  reg_write_s = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      ALUOP_SUB:   ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        // Only register-register ops (OP[5]=1) may select sub
        case (funct3)
          3'b000:  ALUControl = (OP[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    take = 1'b0;
    if (funct3 == 3'b000)      take = Zero;
    else if (funct3 == 3'b001) take = ~Zero;
  end

  assign PCWrite  = ~RESET & (pc_update | (branch & take));
  assign MemWrite = ~RESET & mem_write_s;
  assign RegWrite = ~RESET & reg_write_s;
  assign IRWrite  = ~RESET & ir_write_s;
  assign Illegal  = ~RESET & (state == ILLEGAL);

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Bench for multi_cycle_controller: per-instruction cycle tables from the ISA sequencing rules, random instruction mix.
module tb_multi_cycle_controller;

  typedef struct packed {
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] imm;
    logic [1:0] res;
    logic [2:0] aluc;
    logic       adr;
    logic       pcw;
    logic       memw;
    logic       regw;
    logic       irw;
    logic       ill;
  } outs_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [6:0] OP = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7 = 1'b0;
  logic       Zero = 1'b0;
  logic [1:0] ALUSrcA, ALUSrcB, ImmSrc, ResultSrc;
  logic [2:0] ALUControl;
  logic       AdrSrc, PCWrite, MemWrite, RegWrite, IRWrite, Illegal;

  int total = 0;
  int bad   = 0;

  multi_cycle_controller dut (
    .CLK(CLK), .RESET(RESET), .OP(OP), .funct3(funct3), .funct7(funct7), .Zero(Zero),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .AdrSrc(AdrSrc), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .IRWrite(IRWrite), .Illegal(Illegal)
  );

  always #5 CLK = ~CLK;

  outs_t obs;
  assign obs = '{srca: ALUSrcA, srcb: ALUSrcB, imm: ImmSrc, res: ResultSrc, aluc: ALUControl,
                 adr: AdrSrc, pcw: PCWrite, memw: MemWrite, regw: RegWrite, irw: IRWrite, ill: Illegal};

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%05h exp=%05h", tag, got, exp);
    end
  endtask

  // Cycles an instruction occupies; an illegal opcode never completes.
  function automatic int instr_len(input logic [6:0] op);
    case (op)
      7'b0000011: return 5;
      7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111: return 4;
      7'b1100011: return 3;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [2:0] alu_ref(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (op == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic outs_t reset_out();
    outs_t o = '0;
    o.srcb = 2'b10;
    o.res  = 2'b10;
    return o;
  endfunction

  // Expected outputs for cycle 'step' (0 = fetch) of an instruction.
  function automatic outs_t expect_out(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                       input logic z, input int step);
    outs_t o = '0;
    if (step == 0) begin
      o.srcb = 2'b10; o.res = 2'b10; o.irw = 1'b1; o.pcw = 1'b1;
    end else if (step == 1) begin
      o.srca = 2'b01; o.srcb = 2'b01; o.imm = 2'b10;
    end else begin
      case (op)
        7'b0000011: begin
          if (step == 2) begin o.srca = 2'b10; o.srcb = 2'b01; end
          else if (step == 3) o.adr = 1'b1;
          else begin o.res = 2'b01; o.regw = 1'b1; end
        end
        7'b0100011: begin
          if (step == 2) begin o.srca = 2'b10; o.srcb = 2'b01; o.imm = 2'b01; end
          else begin o.adr = 1'b1; o.memw = 1'b1; end
        end
        7'b0110011: begin
          if (step == 2) begin o.srca = 2'b10; o.aluc = alu_ref(op, f3, f7); end
          else o.regw = 1'b1;
        end
        7'b0010011: begin
          if (step == 2) begin o.srca = 2'b10; o.srcb = 2'b01; o.aluc = alu_ref(op, f3, f7); end
          else o.regw = 1'b1;
        end
        7'b1100011: begin
          o.srca = 2'b10; o.aluc = 3'b001;
          o.pcw  = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? ~z : 1'b0);
        end
        7'b1101111: begin
          if (step == 2) begin o.srca = 2'b01; o.srcb = 2'b10; o.pcw = 1'b1; end
          else o.regw = 1'b1;
        end
        default: o.ill = 1'b1;
      endcase
    end
    return o;
  endfunction

  // Enters and leaves at a falling edge; nsteps=0 runs the whole instruction.
  task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int nsteps);
    int n = (nsteps > 0) ? nsteps : instr_len(op);
    OP = op; funct3 = f3; funct7 = f7; Zero = z;
    for (int s = 0; s < n; s++) begin
      #1;
      chk($sformatf("%s s%0d", name, s), obs, expect_out(op, f3, f7, z, s));
      @(negedge CLK);
    end
  endtask

  task automatic do_reset(input string name);
    RESET = 1'b1;
    #1 chk({name, " rst"}, obs, reset_out());
    @(posedge CLK);
    #1 chk({name, " rst_edge"}, obs, reset_out());
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  initial begin
    logic [6:0] ops [6];
    logic [6:0] op;
    logic [2:0] f3;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

    repeat (2) @(negedge CLK);
    do_reset("init");

    run_instr("lw",       7'b0000011, 3'b010, 1'b0, 1'b0, 0);
    run_instr("sw",       7'b0100011, 3'b010, 1'b0, 1'b1, 0);
    run_instr("sub",      7'b0110011, 3'b000, 1'b1, 1'b0, 0);
    run_instr("addi_f7",  7'b0010011, 3'b000, 1'b1, 1'b0, 0);
    run_instr("slt",      7'b0110011, 3'b010, 1'b0, 1'b0, 0);
    run_instr("slti",     7'b0010011, 3'b010, 1'b0, 1'b0, 0);
    run_instr("beq_z1",   7'b1100011, 3'b000, 1'b0, 1'b1, 0);
    run_instr("bne_z1",   7'b1100011, 3'b001, 1'b0, 1'b1, 0);
    run_instr("beq_z0",   7'b1100011, 3'b000, 1'b0, 1'b0, 0);
    run_instr("bne_z0",   7'b1100011, 3'b001, 1'b0, 1'b0, 0);
    run_instr("jal",      7'b1101111, 3'b000, 1'b0, 1'b0, 0);

    // Abort a load in MEMREAD, then a store in MEMADR
    run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, 1'b0, 3);
    do_reset("lw_abort");
    run_instr("sw_abort", 7'b0100011, 3'b010, 1'b0, 1'b0, 2);
    do_reset("sw_abort");

    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 5)];
      f3 = (op == 7'b1100011) ? 3'($urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      run_instr($sformatf("rnd%0d_op%02h", i, op), op, f3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 19) == 0) begin
        run_instr($sformatf("rnd%0d_part", i), op, f3, 1'b0, 1'b0, $urandom_range(1, 2));
        do_reset($sformatf("rnd%0d", i));
      end
    end

    // Illegal opcode locks up until reset
    run_instr("illegal", 7'b1111111, 3'b000, 1'b0, 1'b0, 12);
    do_reset("illegal");
    run_instr("post_ill", 7'b0110011, 3'b111, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
